// File: rtl/pipe_add_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_add_pkg
// Purpose  : Shared defaults and elaboration helpers for the segmented adder.
// Revision : 1.0 - initial release
// ============================================================================
package pipe_add_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;
  localparam int CLA_GROUP = 4;

  // Bit offset of the operand bits that stage k carries forward inside the
  // flat delay vector; stage k forwards WIDTH-(k+1)*SEG bits.
  function automatic int rem_offset(input int width, input int seg, input int k);
    int off;
    off = 0;
    for (int j = 0; j < k; j++) begin
      off += width - (j + 1) * seg;
    end
    return off;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_add_seg.sv
`default_nettype none
// ============================================================================
// Module   : pipe_add_seg
// Purpose  : Combinational SEG-bit adder slice: sum, carry-out, MSB carry-in.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_add_seg
  import pipe_add_pkg::*;
#(
  parameter int SEG = DEF_SEG
) (
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           cm
);

  logic [SEG-1:0] g;
  logic [SEG-1:0] p;
  logic [SEG:0]   c;

  assign g = a & b;
  assign p = a ^ b;

  generate
    if (SEG % CLA_GROUP == 0) begin : g_cla
      logic [CLA_GROUP-1:0] gg;
      logic [CLA_GROUP-1:0] pg;
      logic                 cg;

      // 4-bit lookahead groups, rippling group carry between groups.
      always_comb begin
        c    = '0;
        gg   = '0;
        pg   = '0;
        cg   = 1'b0;
        c[0] = ci;
        for (int n = 0; n < SEG / CLA_GROUP; n++) begin
          gg = g[n*CLA_GROUP +: CLA_GROUP];
          pg = p[n*CLA_GROUP +: CLA_GROUP];
          cg = c[n*CLA_GROUP];
          c[n*CLA_GROUP+1] = gg[0] | (pg[0] & cg);
          c[n*CLA_GROUP+2] = gg[1] | (pg[1] & gg[0]) | (pg[1] & pg[0] & cg);
          c[n*CLA_GROUP+3] = gg[2] | (pg[2] & gg[1]) | (pg[2] & pg[1] & gg[0])
                           | (pg[2] & pg[1] & pg[0] & cg);
          c[n*CLA_GROUP+4] = gg[3] | (pg[3] & gg[2]) | (pg[3] & pg[2] & gg[1])
                           | (pg[3] & pg[2] & pg[1] & gg[0])
                           | (pg[3] & pg[2] & pg[1] & pg[0] & cg);
        end
      end
    end else begin : g_ripple
      always_comb begin
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
          c[i+1] = g[i] | (p[i] & c[i]);
        end
      end
    end
  endgenerate

  assign s  = p ^ c[SEG-1:0];
  assign co = c[SEG];
  assign cm = c[SEG-1];

endmodule
`default_nettype wire

// File: rtl/pipe_add.sv
`default_nettype none
// ============================================================================
// Module   : pipe_add
// Purpose  : Pipelined add/sub, one SEG-bit segment per stage, valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_add
  import pipe_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SEG   = DEF_SEG
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES   = WIDTH / SEG;
  localparam int PIPE_N   = (STAGES > 1) ? STAGES - 1 : 1;
  localparam int REM_RAW  = rem_offset(WIDTH, SEG, STAGES - 1);
  localparam int REM_BITS = (REM_RAW > 0) ? REM_RAW : 1;

  generate
    if ((WIDTH % SEG != 0) || (SEG > WIDTH)) begin : g_bad_params
      $fatal(1, "pipe_add: WIDTH must be a non-zero multiple of SEG");
    end
  endgenerate

  logic                         adv;
  logic [PIPE_N-1:0]            v_q, v_d;
  logic [PIPE_N-1:0]            c_q, c_d;
  logic [PIPE_N-1:0][WIDTH-1:0] s_q, s_d;
  logic [REM_BITS-1:0]          ra_q, ra_d;
  logic [REM_BITS-1:0]          rb_q, rb_d;
  logic                         last_v, last_co, last_ov;
  logic [WIDTH-1:0]             last_s;

  // Whole pipe moves in lock-step; nothing advances while the output stalls.
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      localparam int LO  = k * SEG;
      localparam int REM = WIDTH - LO;

      logic [REM-1:0]   a_in, b_in;
      logic [WIDTH-1:0] s_in, s_out;
      logic             c_in, v_in;
      logic [SEG-1:0]   seg_s;
      logic             seg_co;

      if (k == 0) begin : g_head
        assign a_in = a;
        assign b_in = b ^ {WIDTH{sub}};
        assign s_in = '0;
        assign c_in = cin ^ sub;
        assign v_in = in_valid & adv;
      end else begin : g_body
        localparam int OFF_IN = rem_offset(WIDTH, SEG, k - 1);
        assign a_in = ra_q[OFF_IN +: REM];
        assign b_in = rb_q[OFF_IN +: REM];
        assign s_in = s_q[k-1];
        assign c_in = c_q[k-1];
        assign v_in = v_q[k-1];
      end

      assign s_out = s_in | (WIDTH'(seg_s) << LO);

      if (k < STAGES - 1) begin : g_fwd
        localparam int OFF = rem_offset(WIDTH, SEG, k);
        logic unused_cm;

        pipe_add_seg #(.SEG(SEG)) u_seg (
          .a  (a_in[SEG-1:0]),
          .b  (b_in[SEG-1:0]),
          .ci (c_in),
          .s  (seg_s),
          .co (seg_co),
          .cm (unused_cm)
        );

        assign ra_d[OFF +: REM-SEG] = a_in[REM-1:SEG];
        assign rb_d[OFF +: REM-SEG] = b_in[REM-1:SEG];
        assign s_d[k]               = s_out;
        assign c_d[k]               = seg_co;
        assign v_d[k]               = v_in;
      end else begin : g_tail
        logic seg_cm;

        pipe_add_seg #(.SEG(SEG)) u_seg (
          .a  (a_in[SEG-1:0]),
          .b  (b_in[SEG-1:0]),
          .ci (c_in),
          .s  (seg_s),
          .co (seg_co),
          .cm (seg_cm)
        );

        assign last_s  = s_out;
        assign last_co = seg_co;
        assign last_ov = seg_co ^ seg_cm;
        assign last_v  = v_in;
      end
    end

    if (STAGES == 1) begin : g_single
      assign v_d  = '0;
      assign c_d  = '0;
      assign s_d  = '0;
      assign ra_d = '0;
      assign rb_d = '0;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q       <= '0;
      c_q       <= '0;
      s_q       <= '0;
      ra_q      <= '0;
      rb_q      <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
    end else if (adv) begin
      v_q       <= v_d;
      c_q       <= c_d;
      s_q       <= s_d;
      ra_q      <= ra_d;
      rb_q      <= rb_d;
      out_valid <= last_v;
      sum       <= last_s;
      cout      <= last_co;
      ovf       <= last_ov;
      zero      <= (last_s == '0);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_add.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_add
// Purpose  : Directed self-checking bench for pipe_add (32/8 and 16/4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_add;

  localparam int W  = 32;
  localparam int ST = 4;

  typedef struct {
    longint unsigned s;
    bit              co;
    bit              ov;
    bit              z;
  } res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    bit          cin;
    bit          sub;
    logic [31:0] lsum;
    bit          lco;
    bit          lov;
    bit          lz;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, out_ready = 1'b1, cin = 1'b0, sub = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] sum;

  logic        in_valid16 = 1'b0, cin16 = 1'b0, sub16 = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        in_ready16, out_valid16, cout16, ovf16, zero16;
  logic [15:0] sum16;
  logic        out_ready16 = 1'b1;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  pipe_add #(.WIDTH(32), .SEG(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid),
    .out_ready(out_ready), .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  pipe_add #(.WIDTH(16), .SEG(4)) u_dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .cin(cin16), .sub(sub16), .out_valid(out_valid16),
    .out_ready(out_ready16), .sum(sum16), .cout(cout16), .ovf(ovf16), .zero(zero16)
  );

  // Arithmetic meaning of the operation, independent of any segmenting.
  function automatic res_t model(input int w, input longint unsigned x,
                                 input longint unsigned y, input bit ci, input bit sb);
    res_t            r;
    longint unsigned mask;
    longint          half, sx, sy, sr;
    mask = (64'd1 << w) - 64'd1;
    half = longint'(64'd1 << (w - 1));
    sx = longint'(x);
    sy = longint'(y);
    if (sx >= half) sx = sx - 2 * half;
    if (sy >= half) sy = sy - 2 * half;
    if (!sb) begin
      r.s  = (x + y + ci) & mask;
      r.co = ((x + y + ci) > mask);
      sr   = sx + sy + ci;
    end else begin
      r.s  = (x - y - ci) & mask;
      r.co = (x >= y + ci);
      sr   = sx - sy - ci;
    end
    r.ov = (sr > half - 1) || (sr < -half);
    r.z  = (r.s == 0);
    return r;
  endfunction

  task automatic check(input string name, input bit ok,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Expected-occupancy model: an op enters when accepted and surfaces ST edges later.
  bit   m_v[ST];
  res_t m_res[ST];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ST; i++) m_v[i] <= 1'b0;
    end else if (!m_v[ST-1] || out_ready) begin
      for (int i = ST - 1; i > 0; i--) begin
        m_v[i]   <= m_v[i-1];
        m_res[i] <= m_res[i-1];
      end
      m_v[0]   <= in_valid;
      m_res[0] <= model(W, a, b, cin, sub);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      check("in_ready", in_ready === (!m_v[ST-1] || out_ready),
            64'(in_ready), 64'(!m_v[ST-1] || out_ready));
      check("out_valid", out_valid === m_v[ST-1], 64'(out_valid), 64'(m_v[ST-1]));
      if (m_v[ST-1]) begin
        check("result", {sum, cout, ovf, zero} ===
              {m_res[ST-1].s[31:0], m_res[ST-1].co, m_res[ST-1].ov, m_res[ST-1].z},
              64'({sum, cout, ovf, zero}),
              64'({m_res[ST-1].s[31:0], m_res[ST-1].co, m_res[ST-1].ov, m_res[ST-1].z}));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] ta, input logic [31:0] tb_b,
                       input bit tc, input bit ts, input bit tv);
    a = ta; b = tb_b; cin = tc; sub = ts; in_valid = tv;
  endtask

  task automatic issue_one(input vec_t v, input string nm);
    int n;
    n = 0;
    drive(v.a, v.b, v.cin, v.sub, 1'b1);
    do begin
      tick();
      n++;
      if (n == 1) in_valid = 1'b0;
    end while (!out_valid && n < 10);
    check({nm, " latency"}, (n == 4) && out_valid, 64'(n), 64'd4);
    check({nm, " literal"}, {sum, cout, ovf, zero} === {v.lsum, v.lco, v.lov, v.lz},
          64'({sum, cout, ovf, zero}), 64'({v.lsum, v.lco, v.lov, v.lz}));
  endtask

  vec_t vecs[5];
  res_t r;
  int   ones, run, best, n16;
  logic [31:0] held;

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0};
    vecs[2] = '{32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0};

    foreach (vecs[i]) begin
      r = model(W, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
      check("model pin", {r.s[31:0], r.co, r.ov, r.z} ===
            {vecs[i].lsum, vecs[i].lco, vecs[i].lov, vecs[i].lz},
            64'({r.s[31:0], r.co, r.ov, r.z}),
            64'({vecs[i].lsum, vecs[i].lco, vecs[i].lov, vecs[i].lz}));
    end
    r = model(16, 64'h7FFF, 64'h0001, 1'b0, 1'b0);
    check("model pin16", {r.s[15:0], r.co, r.ov, r.z} === {16'h8000, 1'b0, 1'b1, 1'b0},
          64'({r.s[15:0], r.co, r.ov, r.z}), 64'({16'h8000, 1'b0, 1'b1, 1'b0}));

    #2;
    check("reset outs", {out_valid, sum, cout, ovf, zero} === '0,
          64'({out_valid, sum, cout, ovf, zero}), 64'd0);
    check("reset in_ready", in_ready === 1'b1, 64'(in_ready), 64'd1);
    tick(); tick();
    rst = 1'b0;
    tick();

    // Single ops: carry wrap, signed-overflow subtract, borrow, add overflow, borrow-in.
    issue_one(vecs[0], "add wrap");
    issue_one(vecs[1], "sub ovf");
    issue_one(vecs[2], "sub borrow");
    issue_one(vecs[3], "add ovf");
    issue_one(vecs[4], "sub bin");
    tick(); tick();

    // Back-to-back stream: eight results on eight consecutive cycles.
    ones = 0; run = 0; best = 0;
    for (int i = 1; i <= 16; i++) begin
      if (i <= 8) drive(32'(i), 32'h00FF_00FF * 32'(i), 1'b0, 1'b0, 1'b1);
      else in_valid = 1'b0;
      tick();
      if (out_valid) begin ones++; run++; end
      else run = 0;
      if (run > best) best = run;
    end
    check("stream count", ones == 8, 64'(ones), 64'd8);
    check("stream run", best == 8, 64'(best), 64'd8);

    // Fill, then stall three cycles with the input side changing underneath.
    for (int i = 0; i < 4; i++) begin
      drive(32'h1000_0000 * 32'(i + 1), 32'h0123_4567 + 32'(i), 1'(i), 1'(i & 1), 1'b1);
      tick();
    end
    out_ready = 1'b0;
    held = sum;
    for (int i = 0; i < 3; i++) begin
      drive(32'hDEAD_0000 + 32'(i), 32'hBEEF_0000, 1'b1, 1'b1, 1'b1);
      tick();
      check("stall hold", sum === held && out_valid && !in_ready, 64'(sum), 64'(held));
    end
    drive(32'h0000_00AA, 32'h0000_0055, 1'b0, 1'b1, 1'b1);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();

    // Reset with work in flight.
    for (int i = 0; i < 4; i++) begin
      drive(32'(i + 3), 32'(i + 9), 1'b0, 1'b0, 1'b1);
      tick();
    end
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async reset", {out_valid, sum, cout, ovf, zero} === '0 && in_ready === 1'b1,
          64'({out_valid, sum, cout, ovf, zero}), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    ones = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) ones++;
    end
    check("no stale", ones == 0, 64'(ones), 64'd0);
    issue_one(vecs[1], "post reset");
    tick();

    // 16-bit instance, 4-bit segments.
    a16 = 16'h7FFF; b16 = 16'h0001; cin16 = 1'b0; sub16 = 1'b0; in_valid16 = 1'b1;
    n16 = 0;
    do begin
      tick();
      n16++;
      if (n16 == 1) in_valid16 = 1'b0;
    end while (!out_valid16 && n16 < 10);
    check("w16 latency", (n16 == 4) && out_valid16, 64'(n16), 64'd4);
    check("w16 literal", {sum16, cout16, ovf16, zero16} === {16'h8000, 1'b0, 1'b1, 1'b0},
          64'({sum16, cout16, ovf16, zero16}), 64'({16'h8000, 1'b0, 1'b1, 1'b0}));
    r = model(16, 64'(a16), 64'(b16), cin16, sub16);
    check("w16 model", {sum16, cout16, ovf16, zero16} === {r.s[15:0], r.co, r.ov, r.z},
          64'({sum16, cout16, ovf16, zero16}), 64'({r.s[15:0], r.co, r.ov, r.z}));

    tick(); tick();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
